// File: rtl/ks_subtractor_pipe_if.sv
// Operand/result handshake bundle for the pipelined Kogge-Stone subtractor.
// The producer drives operands and out_ready; the subtractor drives everything else.
interface ks_subtractor_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf, zero
    );
endinterface

// File: rtl/ks_subtractor_pipe.sv
// Pipelined Kogge-Stone subtractor: diff = a - b - bin, computed as a + ~b + ~bin
// with one register per prefix level and a single global stall enable.
module ks_subtractor_pipe #(
    parameter int WIDTH = 16
) (
    input logic                 clk,
    input logic                 rst,
    ks_subtractor_pipe_if.slave bus
);
    localparam int LEVELS = $clog2(WIDTH);

    // Index k holds the state registered after prefix level k (k = 0 is the p/g stage).
    logic [LEVELS:0][WIDTH-1:0]   g_q;
    logic [LEVELS-1:0][WIDTH-1:0] p_q;
    logic [LEVELS:0][WIDTH-1:0]   po_q;
    logic [LEVELS:0]              v_q;
    logic [LEVELS:0]              cin_q;
    logic [LEVELS:0]              am_q;
    logic [LEVELS:0]              bm_q;

    logic [LEVELS:1][WIDTH-1:0]   g_nxt;
    logic [LEVELS-1:1][WIDTH-1:0] p_nxt;

    logic [WIDTH-1:0] p0;
    logic [WIDTH-1:0] g0;
    logic             cin0;
    logic [WIDTH-1:0] diff_n;
    logic             bout_n;
    logic             ovf_n;
    logic             zero_n;

    logic             out_valid_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             ovf_q;
    logic             zero_q;
    logic             adv;

    assign adv          = !(out_valid_q && !bus.out_ready);
    assign bus.in_ready = adv;

    always_comb begin
        cin0  = ~bus.bin;
        p0    = bus.a ^ ~bus.b;
        g0    = bus.a & ~bus.b;
        // Gray cell at bit 0 absorbs the carry-in, so every prefix G becomes a true carry.
        g0[0] = (bus.a[0] & ~bus.b[0]) | (p0[0] & cin0);
    end

    always_comb begin
        g_nxt = '0;
        p_nxt = '0;
        for (int unsigned k = 1; k <= LEVELS; k++) begin
            g_nxt[k] = g_q[k-1];
            for (int unsigned i = (1 << (k - 1)); i < WIDTH; i++) begin
                g_nxt[k][i] = g_q[k-1][i] | (p_q[k-1][i] & g_q[k-1][i - (1 << (k - 1))]);
            end
        end
        // The last level never needs P, so propagate terms stop one level early.
        for (int unsigned k = 1; k < LEVELS; k++) begin
            p_nxt[k] = p_q[k-1];
            for (int unsigned i = (1 << (k - 1)); i < WIDTH; i++) begin
                p_nxt[k][i] = p_q[k-1][i] & p_q[k-1][i - (1 << (k - 1))];
            end
        end
    end

    always_comb begin
        diff_n = po_q[LEVELS] ^ {g_q[LEVELS][WIDTH-2:0], cin_q[LEVELS]};
        bout_n = ~g_q[LEVELS][WIDTH-1];
        ovf_n  = (am_q[LEVELS] != bm_q[LEVELS]) && (diff_n[WIDTH-1] != am_q[LEVELS]);
        zero_n = (diff_n == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q         <= '0;
            g_q         <= '0;
            p_q         <= '0;
            po_q        <= '0;
            cin_q       <= '0;
            am_q        <= '0;
            bm_q        <= '0;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (adv) begin
            v_q[0]   <= bus.in_valid;
            g_q[0]   <= g0;
            p_q[0]   <= p0;
            po_q[0]  <= p0;
            cin_q[0] <= cin0;
            am_q[0]  <= bus.a[WIDTH-1];
            bm_q[0]  <= bus.b[WIDTH-1];
            for (int unsigned k = 1; k <= LEVELS; k++) begin
                v_q[k]   <= v_q[k-1];
                g_q[k]   <= g_nxt[k];
                po_q[k]  <= po_q[k-1];
                cin_q[k] <= cin_q[k-1];
                am_q[k]  <= am_q[k-1];
                bm_q[k]  <= bm_q[k-1];
            end
            for (int unsigned k = 1; k < LEVELS; k++) begin
                p_q[k] <= p_nxt[k];
            end
            out_valid_q <= v_q[LEVELS];
            // Result fields only move when a real result arrives, so bubbles never expose junk.
            if (v_q[LEVELS]) begin
                diff_q <= diff_n;
                bout_q <= bout_n;
                ovf_q  <= ovf_n;
                zero_q <= zero_n;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_ks_subtractor_pipe.sv
// Directed and streaming checks for ks_subtractor_pipe at WIDTH=16.
module tb_ks_subtractor_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [18:0] exp_q[$];

    ks_subtractor_pipe_if #(.WIDTH(16)) bus ();

    ks_subtractor_pipe #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam logic [15:0] TA  [7] = '{16'h0005, 16'h0003, 16'h8000, 16'h1234, 16'h0000, 16'h5A5A, 16'h7FFF};
    localparam logic [15:0] TBV [7] = '{16'h0003, 16'h0005, 16'h0001, 16'h1233, 16'h0000, 16'h5A5A, 16'hFFFF};
    localparam logic [15:0] TD  [7] = '{16'h0002, 16'hFFFE, 16'h7FFF, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h8000};
    localparam logic [6:0]  TBIN = 7'b0111000;
    localparam logic [6:0]  TBO  = 7'b1110010;
    localparam logic [6:0]  TOV  = 7'b1000100;
    localparam logic [6:0]  TZ   = 7'b0001000;

    // Reference result packed as {ovf, zero, bout, diff}.
    function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b, input logic bin);
        logic [16:0] r;
        logic        ov;
        r  = {1'b0, a} - {1'b0, b} - {16'd0, bin};
        ov = (a[15] != b[15]) && (r[15] != a[15]);
        return {ov, (r[15:0] == 16'd0), r[16], r[15:0]};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.a = '0;
        bus.b = '0;
        bus.bin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        n_cmp++; if (bus.diff !== 16'h0000) begin n_err++; $display("FAIL reset_diff got=%h want=0000", bus.diff); end
        n_cmp++; if (bus.bout !== 1'b0) begin n_err++; $display("FAIL reset_bout got=%b want=0", bus.bout); end
        n_cmp++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b want=0", bus.ovf); end
        n_cmp++; if (bus.zero !== 1'b0) begin n_err++; $display("FAIL reset_zero got=%b want=0", bus.zero); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    endtask

    task automatic test_directed();
        int lat;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            bus.a = TA[i];
            bus.b = TBV[i];
            bus.bin = TBIN[i];
            bus.in_valid = 1'b1;
            lat = 0;
            do begin
                @(posedge clk); #1;
                bus.in_valid = 1'b0;
                lat++;
            end while (!bus.out_valid && lat < 20);
            n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL dir%0d_latency got=%0d want=6", i, lat); end
            n_cmp++; if (bus.diff !== TD[i]) begin n_err++; $display("FAIL dir%0d_diff got=%h want=%h", i, bus.diff, TD[i]); end
            n_cmp++; if (bus.bout !== TBO[i]) begin n_err++; $display("FAIL dir%0d_bout got=%b want=%b", i, bus.bout, TBO[i]); end
            n_cmp++; if (bus.ovf !== TOV[i]) begin n_err++; $display("FAIL dir%0d_ovf got=%b want=%b", i, bus.ovf, TOV[i]); end
            n_cmp++; if (bus.zero !== TZ[i]) begin n_err++; $display("FAIL dir%0d_zero got=%b want=%b", i, bus.zero, TZ[i]); end
            @(posedge clk); #1;
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL dir%0d_single got=%b want=0", i, bus.out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got = 0;
        int gaps = 0;
        int cyc = 0;
        logic [18:0] e;
        logic [18:0] o;
        exp_q.delete();
        while (got < 100 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            bus.out_ready = 1'b1;
            bus.in_valid = (sent < 100);
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
            bus.bin = 1'($urandom);
            #1;
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready cyc=%0d got=%b want=1", cyc, bus.in_ready); end
            if (bus.out_valid && bus.out_ready) begin
                o = {bus.ovf, bus.zero, bus.bout, bus.diff};
                n_cmp++;
                if (exp_q.size() == 0) begin n_err++; $display("FAIL b2b_extra got=%h want=none", o); end
                else begin
                    e = exp_q.pop_front();
                    if (o !== e) begin n_err++; $display("FAIL b2b_result%0d got=%h want=%h", got, o, e); end
                end
                got++;
            end else if (got > 0) gaps++;
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.a, bus.b, bus.bin));
                sent++;
            end
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (got !== 100) begin n_err++; $display("FAIL b2b_count got=%0d want=100", got); end
        n_cmp++; if (gaps !== 0) begin n_err++; $display("FAIL b2b_gaps got=%0d want=0", gaps); end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int stalls = 0;
        logic pend = 1'b0;
        logic stall_prev = 1'b0;
        logic [15:0] diff_prev = '0;
        logic [18:0] e;
        logic [18:0] o;
        exp_q.delete();
        while (got < 10 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (stall_prev) begin
                n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid cyc=%0d got=%b want=1", cyc, bus.out_valid); end
                n_cmp++; if (bus.diff !== diff_prev) begin n_err++; $display("FAIL bp_hold_diff cyc=%0d got=%h want=%h", cyc, bus.diff, diff_prev); end
            end
            bus.out_ready = !(cyc >= 8 && cyc < 12);
            if (!pend && sent < 10) begin
                bus.a = 16'($urandom);
                bus.b = 16'($urandom);
                bus.bin = 1'($urandom);
                pend = 1'b1;
            end
            bus.in_valid = pend;
            #1;
            stall_prev = bus.out_valid && !bus.out_ready;
            if (stall_prev) begin
                stalls++;
                diff_prev = bus.diff;
                n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", cyc, bus.in_ready); end
            end
            if (bus.out_valid && bus.out_ready) begin
                o = {bus.ovf, bus.zero, bus.bout, bus.diff};
                n_cmp++;
                if (exp_q.size() == 0) begin n_err++; $display("FAIL bp_extra got=%h want=none", o); end
                else begin
                    e = exp_q.pop_front();
                    if (o !== e) begin n_err++; $display("FAIL bp_result%0d got=%h want=%h", got, o, e); end
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.a, bus.b, bus.bin));
                sent++;
                pend = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        n_cmp++; if (got !== 10) begin n_err++; $display("FAIL bp_count got=%0d want=10", got); end
        n_cmp++; if (stalls !== 4) begin n_err++; $display("FAIL bp_stall_cycles got=%0d want=4", stalls); end
        n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL bp_leftover got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_bubbles();
        logic acc[40];
        logic want;
        logic [18:0] e;
        logic [18:0] o;
        exp_q.delete();
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
            bus.in_valid = (c < 12) && (c % 2 == 0);
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
            bus.bin = 1'($urandom);
            #1;
            acc[c] = bus.in_valid && bus.in_ready;
            want = (c >= 6) ? acc[c-6] : 1'b0;
            n_cmp++; if (bus.out_valid !== want) begin n_err++; $display("FAIL bub_valid c=%0d got=%b want=%b", c, bus.out_valid, want); end
            if (bus.out_valid && bus.out_ready) begin
                o = {bus.ovf, bus.zero, bus.bout, bus.diff};
                n_cmp++;
                if (exp_q.size() == 0) begin n_err++; $display("FAIL bub_extra got=%h want=none", o); end
                else begin
                    e = exp_q.pop_front();
                    if (o !== e) begin n_err++; $display("FAIL bub_result c=%0d got=%h want=%h", c, o, e); end
                end
            end
            if (acc[c]) exp_q.push_back(model(bus.a, bus.b, bus.bin));
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int lat;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            bus.a = 16'hA000 + 16'(c);
            bus.b = 16'h0100;
            bus.bin = 1'b0;
            bus.in_valid = 1'b1;
            rst = (c == 2);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_out_valid got=%b want=0", bus.out_valid); end
        n_cmp++; if (bus.diff !== 16'h0000) begin n_err++; $display("FAIL rmid_diff got=%h want=0000", bus.diff); end
        n_cmp++; if (bus.bout !== 1'b0) begin n_err++; $display("FAIL rmid_bout got=%b want=0", bus.bout); end
        n_cmp++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL rmid_ovf got=%b want=0", bus.ovf); end
        n_cmp++; if (bus.zero !== 1'b0) begin n_err++; $display("FAIL rmid_zero got=%b want=0", bus.zero); end
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rmid_ghost got=%0d want=0", seen); end
        bus.a = 16'h00FF;
        bus.b = 16'h0F0F;
        bus.bin = 1'b0;
        bus.in_valid = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            lat++;
        end while (!bus.out_valid && lat < 20);
        n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL rmid_latency got=%0d want=6", lat); end
        n_cmp++; if (bus.diff !== 16'hF1F0) begin n_err++; $display("FAIL rmid_diff2 got=%h want=F1F0", bus.diff); end
        n_cmp++; if (bus.bout !== 1'b1) begin n_err++; $display("FAIL rmid_bout2 got=%b want=1", bus.bout); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic pend = 1'b0;
        logic [18:0] e;
        logic [18:0] o;
        exp_q.delete();
        while (got < 10000 && cyc < 60000) begin
            @(posedge clk); #1;
            cyc++;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!pend && sent < 10000) begin
                bus.a = 16'($urandom);
                bus.b = 16'($urandom);
                bus.bin = 1'($urandom);
                pend = 1'b1;
            end
            bus.in_valid = pend;
            #1;
            if (bus.out_valid && bus.out_ready) begin
                o = {bus.ovf, bus.zero, bus.bout, bus.diff};
                n_cmp++;
                if (exp_q.size() == 0) begin n_err++; $display("FAIL rnd_extra got=%h want=none", o); end
                else begin
                    e = exp_q.pop_front();
                    if (o !== e) begin n_err++; $display("FAIL rnd_result%0d got=%h want=%h", got, o, e); end
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.a, bus.b, bus.bin));
                sent++;
                pend = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        n_cmp++; if (got !== 10000) begin n_err++; $display("FAIL rnd_count got=%0d want=10000", got); end
        n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL rnd_leftover got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_bubbles();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
